instr_fetch_unit: RTL and testbench

Instruction fetch front end that consumes the next-PC decision and drives instruction memory. It issues word fetch requests to instruction memory over a req/ack handshake, buffers returned instructions with their PCs in a small queue, and presents them to the ID stage over a valid/ready interface. A redirect (taken branch, call, or jmpl target) flushes all queued and in-flight fetches and restarts fetching at the new target.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/instr_fetch_unit.sv | 108 ++++++++++
 tb/tb_instr_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int          INSTR_W        = 32;
  localparam int          PC_W           = 32;
  localparam logic [31:0] PC_INC         = 32'd4;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_WAIT,
    FETCH_DISCARD
  } fetch_state_e;

  // Fetch addresses are word aligned; the low two bits are always cleared.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for the fetch unit: redirect input, instruction memory
// req/ack port and the valid/ready handoff to the ID stage.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_target;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [PC_W-1:0]    id_pc;
  logic               id_ready;

  // Fetch unit side.
  modport master (
    input  redirect_valid, redirect_target, imem_ack, imem_rdata, id_ready,
    output imem_req, imem_addr, id_valid, id_instr, id_pc
  );

  // Environment side (memory, branch unit, ID stage).
  modport slave (
    output redirect_valid, redirect_target, imem_ack, imem_rdata, id_ready,
    input  imem_req, imem_addr, id_valid, id_instr, id_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer holding fetched {pc, instr} entries until ID takes them.
// Flush empties the buffer and overrides any push or pop in that cycle.
module fetch_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push_ok;
  logic              pop_ok;

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^n.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: one outstanding word request at a time,
// returned words queued with their PC, redirects flush everything queued
// and retire any in-flight request without using its data.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input logic                clk,
  input logic                clr,
  instr_fetch_unit_if.master bus
);

  localparam int ENTRY_W = PC_W + INSTR_W;

  fetch_state_e        state;
  fetch_state_e        state_nxt;
  logic [PC_W-1:0]     fa;
  logic [PC_W-1:0]     fa_nxt;
  logic [PC_W-1:0]     addr_q;
  logic [PC_W-1:0]     addr_nxt;
  logic [PC_W-1:0]     target;
  logic                fifo_push;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  fifo_head;

  assign target = word_align(bus.redirect_target);

  // FSM state register; reset abandons any in-flight request at once.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= FETCH_IDLE;
    else      state <= state_nxt;
  end

  // Fetch address and request address registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      fa     <= RESET_PC;
      addr_q <= '0;
    end else begin
      fa     <= fa_nxt;
      addr_q <= addr_nxt;
    end
  end

  // Next-state, next-address and queue push decode. In WAIT fa still
  // equals the outstanding address, so it doubles as the pushed PC.
  always_comb begin
    state_nxt = state;
    fa_nxt    = fa;
    addr_nxt  = addr_q;
    fifo_push = 1'b0;
    case (state)
      FETCH_IDLE: begin
        if (bus.redirect_valid) begin
          fa_nxt = target;
        end else if (!fifo_full) begin
          addr_nxt  = fa;
          state_nxt = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (bus.imem_ack) begin
          state_nxt = FETCH_IDLE;
          if (bus.redirect_valid) begin
            fa_nxt = target;
          end else begin
            fifo_push = 1'b1;
            fa_nxt    = fa + PC_INC;
          end
        end else if (bus.redirect_valid) begin
          fa_nxt    = target;
          state_nxt = FETCH_DISCARD;
        end
      end
      FETCH_DISCARD: begin
        // The stale request stays on the bus until acked; latest redirect wins.
        if (bus.redirect_valid) fa_nxt = target;
        if (bus.imem_ack)       state_nxt = FETCH_IDLE;
      end
      default: state_nxt = FETCH_IDLE;
    endcase
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (fifo_push),
    .pop   (bus.id_ready),
    .flush (bus.redirect_valid),
    .din   ({fa, bus.imem_rdata}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_head)
  );

  assign bus.imem_req  = (state != FETCH_IDLE);
  assign bus.imem_addr = addr_q;
  assign bus.id_valid  = !fifo_empty;
  assign bus.id_pc     = fifo_empty ? '0 : fifo_head[ENTRY_W-1:INSTR_W];
  assign bus.id_instr  = fifo_empty ? '0 : fifo_head[INSTR_W-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed phases push the expected
// fetch addresses and expected ID handoffs; a monitor pops and compares.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic clr = 1'b0;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int n_acks    = 0;
  int n_pops    = 0;
  int cyc       = 0;
  int last_ack  = 0;
  bit rate_chk  = 1'b0;
  int ack_budget = 0;
  int ack_delay  = 0;
  int wait_cnt   = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_pc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_pops(input int n, input string name);
    for (int i = 0; i < 300 && n_pops < n; i++) tick();
    chk(name, 32'(n_pops), 32'(n));
  endtask

  task automatic wait_acks(input int n, input string name);
    for (int i = 0; i < 300 && n_acks < n; i++) tick();
    chk(name, 32'(n_acks), 32'(n));
  endtask

  // Instruction memory: acks after ack_delay waiting cycles while budget lasts.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.imem_req && ack_budget > 0) begin
        if (wait_cnt >= ack_delay) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem_word(bus.imem_addr);
          ack_budget--;
          wait_cnt = 0;
        end else begin
          bus.imem_ack   = 1'b0;
          bus.imem_rdata = 32'h0;
          wait_cnt++;
        end
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: sample just before the rising edge, once inputs have settled.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (clr) begin
        if (bus.imem_req && bus.imem_ack) begin
          if (exp_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fetch: got addr %h expected none", bus.imem_addr);
          end else begin
            e = exp_addr.pop_front();
            chk("imem_addr", bus.imem_addr, e);
          end
          if (rate_chk && n_acks > 0) chk("ack_spacing", 32'(cyc - last_ack), 32'd2);
          last_ack = cyc;
          n_acks++;
        end
        if (bus.id_valid && bus.id_ready) begin
          if (exp_pc.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_handoff: got pc %h expected none", bus.id_pc);
          end else begin
            e = exp_pc.pop_front();
            chk("id_pc", bus.id_pc, e);
            chk("id_instr", bus.id_instr, mem_word(e));
          end
          n_pops++;
        end
      end
    end
  end

  initial begin
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    bus.id_ready        = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_id_instr", bus.id_instr, 32'h0);
    chk("rst_id_pc", bus.id_pc, 32'h0);

    // Streaming fetch at full rate
    ack_budget = 4;
    ack_delay  = 0;
    bus.id_ready = 1'b1;
    rate_chk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(32'(i * 4));
      exp_pc.push_back(32'(i * 4));
    end
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("first_req", 32'(bus.imem_req), 32'd1);
    chk("first_addr", bus.imem_addr, 32'h0);
    wait_pops(4, "p1_drain");
    rate_chk = 1'b0;

    // Back-pressure fills the queue
    bus.id_ready = 1'b0;
    ack_budget = 4;
    for (int i = 4; i < 8; i++) exp_addr.push_back(32'(i * 4));
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i >= 16) chk("no_req_when_full", 32'(bus.imem_req), 32'd0);
    end
    chk("p2_acks", 32'(n_acks), 32'd8);
    chk("p2_head_valid", 32'(bus.id_valid), 32'd1);
    chk("p2_head_pc", bus.id_pc, 32'h10);
    for (int i = 4; i < 8; i++) exp_pc.push_back(32'(i * 4));
    bus.id_ready = 1'b1;
    wait_pops(8, "p2_drain");

    // Redirect while IDLE with three queued
    repeat (2) tick();
    bus.id_ready = 1'b0;
    ack_budget = 3;
    exp_addr.push_back(32'h20);
    exp_addr.push_back(32'h24);
    exp_addr.push_back(32'h28);
    wait_acks(11, "p3_acks");
    chk("p3_head_pc", bus.id_pc, 32'h20);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0103;
    @(posedge clk);
    #1;
    chk("p3_flush_valid", 32'(bus.id_valid), 32'd0);
    chk("p3_idle_req", 32'(bus.imem_req), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    ack_budget = 2;
    exp_addr.push_back(32'h100);
    exp_addr.push_back(32'h104);
    exp_pc.push_back(32'h100);
    exp_pc.push_back(32'h104);
    bus.id_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("p3_req", 32'(bus.imem_req), 32'd1);
    chk("p3_addr", bus.imem_addr, 32'h100);
    wait_pops(10, "p3_drain");

    // Redirect during WAIT, ack delayed
    repeat (3) tick();
    chk("p4_wait_req", 32'(bus.imem_req), 32'd1);
    chk("p4_wait_addr", bus.imem_addr, 32'h108);
    exp_addr.push_back(32'h108);
    exp_addr.push_back(32'h200);
    exp_addr.push_back(32'h204);
    exp_pc.push_back(32'h200);
    exp_pc.push_back(32'h204);
    ack_budget = 1;
    ack_delay  = 3;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h200;
    tick();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("p4_discard_req", 32'(bus.imem_req), 32'd1);
      chk("p4_discard_addr", bus.imem_addr, 32'h108);
      tick();
    end
    wait_acks(13, "p4_stale_ack");
    ack_budget = 2;
    ack_delay  = 0;
    wait_pops(12, "p4_drain");

    // Redirect with ack, then two redirects across a DISCARD
    repeat (3) tick();
    chk("p5_wait_addr", bus.imem_addr, 32'h208);
    exp_addr.push_back(32'h208);
    exp_addr.push_back(32'h300);
    exp_addr.push_back(32'h500);
    exp_addr.push_back(32'h504);
    exp_pc.push_back(32'h500);
    exp_pc.push_back(32'h504);
    ack_budget = 1;
    ack_delay  = 2;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.imem_ack) break;
    end
    chk("p5_ack_seen", 32'(bus.imem_ack), 32'd1);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h300;
    @(posedge clk);
    #1;
    chk("p5_idle_req", 32'(bus.imem_req), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("p5_req", 32'(bus.imem_req), 32'd1);
    chk("p5_addr", bus.imem_addr, 32'h300);
    tick();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h400;
    tick();
    bus.redirect_target = 32'h500;
    chk("p5_discard_addr", bus.imem_addr, 32'h300);
    tick();
    bus.redirect_valid = 1'b0;
    ack_budget = 3;
    ack_delay  = 0;
    wait_pops(14, "p5_drain");

    // Address wrap from the top of the space
    repeat (3) tick();
    chk("p6_wait_addr", bus.imem_addr, 32'h508);
    exp_addr.push_back(32'h508);
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_addr.push_back(32'h0);
    exp_pc.push_back(32'hFFFF_FFFC);
    exp_pc.push_back(32'h0);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    ack_budget = 3;
    wait_pops(16, "p6_drain");

    // Reset in the middle of a request
    repeat (3) tick();
    chk("p7_wait_req", 32'(bus.imem_req), 32'd1);
    chk("p7_wait_addr", bus.imem_addr, 32'h4);
    clr = 1'b0;
    #1;
    chk("p7_rst_req", 32'(bus.imem_req), 32'd0);
    chk("p7_rst_addr", bus.imem_addr, 32'h0);
    chk("p7_rst_valid", 32'(bus.id_valid), 32'd0);
    repeat (2) tick();
    exp_addr.push_back(32'h0);
    exp_pc.push_back(32'h0);
    ack_budget = 1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("p7_restart_req", 32'(bus.imem_req), 32'd1);
    chk("p7_restart_addr", bus.imem_addr, 32'h0);
    wait_pops(17, "p7_drain");

    repeat (2) tick();
    chk("exp_addr_left", 32'(exp_addr.size()), 32'd0);
    chk("exp_pc_left", 32'(exp_pc.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
